// File: rtl/lieat_ifu_ifetch_rsp_pkg.sv
// Shared constants and the instruction-buffer entry layout for the IFU fetch-response stage.
package lieat_ifu_ifetch_rsp_pkg;

   localparam int unsigned     XLEN       = 32;
   localparam int unsigned     INST_W     = 32;
   localparam logic [XLEN-1:0] PC_DEFAULT = XLEN'(32'h8000_0000);
   localparam int unsigned     IBUF_W     = XLEN + INST_W + 1;

   typedef struct packed {
      logic [XLEN-1:0]   pc;
      logic [INST_W-1:0] inst;
      logic              err;
   } ibuf_entry_t;

endpackage

// File: rtl/lieat_ifu_ifetch_rsp_if.sv
// Handshake bundle of the fetch-response stage: request input, instruction bus, decode output.
// slave is the fetch-response stage, master is its environment.
interface lieat_ifu_ifetch_rsp_if;
   import lieat_ifu_ifetch_rsp_pkg::*;

   logic              req_i_valid;
   logic [XLEN-1:0]   req_i_pc;
   logic              req_i_ready;
   logic              mem_cmd_valid;
   logic [XLEN-1:0]   mem_cmd_addr;
   logic              mem_cmd_ready;
   logic              mem_rsp_valid;
   logic [INST_W-1:0] mem_rsp_data;
   logic              mem_rsp_err;
   logic              ifu_o_valid;
   logic [XLEN-1:0]   ifu_o_pc;
   logic [INST_W-1:0] ifu_o_inst;
   logic              ifu_o_err;
   logic              ifu_o_ready;

   modport slave (
      input  req_i_valid, req_i_pc, mem_cmd_ready, mem_rsp_valid, mem_rsp_data, mem_rsp_err,
             ifu_o_ready,
      output req_i_ready, mem_cmd_valid, mem_cmd_addr, ifu_o_valid, ifu_o_pc, ifu_o_inst, ifu_o_err
   );

   modport master (
      output req_i_valid, req_i_pc, mem_cmd_ready, mem_rsp_valid, mem_rsp_data, mem_rsp_err,
             ifu_o_ready,
      input  req_i_ready, mem_cmd_valid, mem_cmd_addr, ifu_o_valid, ifu_o_pc, ifu_o_inst, ifu_o_err
   );

endinterface

// File: rtl/lieat_ifu_ifetch_rsp_ibuf.sv
// Synchronous FIFO used for the instruction buffer and the PC queue, plus the
// load-enabled register with synchronous reset used for the stage counters.
module lieat_ifu_ibuf #(
   parameter  int unsigned DEPTH = 4,
   parameter  int unsigned WIDTH = 8,
   localparam int unsigned AW    = $clog2(DEPTH),
   localparam int unsigned CNTW  = $clog2(DEPTH + 1)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic             clear_i,
   input  logic [WIDTH-1:0] wdata_i,
   output logic [WIDTH-1:0] rdata_o,
   output logic             full_o,
   output logic             empty_o,
   output logic [CNTW-1:0]  count_o
);
   localparam int unsigned PW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic             push_ok, pop_ok;

   assign empty_o = (wr_ptr_q == rd_ptr_q);
   assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign count_o = CNTW'(wr_ptr_q - rd_ptr_q);
   assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

   // A full FIFO may still accept a push when the head leaves in the same cycle.
   always_comb begin : ptr_next
      pop_ok   = pop_i & ~empty_o;
      push_ok  = push_i & (~full_o | pop_ok);
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (clear_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
      end else begin
         if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
         if (pop_ok)  rd_ptr_d = rd_ptr_q + PW'(1);
      end
   end

   always_ff @(posedge clock) begin : ptr_reg
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   always_ff @(posedge clock) begin : mem_wr
      if (push_ok && !clear_i) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
   end

endmodule

module lieat_general_dfflr #(
   parameter int unsigned DW = 1
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          lden_i,
   input  logic [DW-1:0] d_i,
   output logic [DW-1:0] q_o
);
   always_ff @(posedge clock) begin : q_reg
      if (reset)       q_o <= '0;
      else if (lden_i) q_o <= d_i;
   end
endmodule

// File: rtl/lieat_ifu_ifetch_rsp.sv
// IFU fetch-response stage: forwards fetch PCs to the bus, drops responses from pre-flush
// fetches and buffers the rest for decode. LIEAT_IFU_RSP_BYPASS_EN adds a zero-latency bypass.
module lieat_ifu_ifetch_rsp
   import lieat_ifu_ifetch_rsp_pkg::*;
#(
   parameter int unsigned IBUF_DEPTH = 4,
   parameter int unsigned OUTS_MAX   = 2
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  flush_i,
   lieat_ifu_ifetch_rsp_if.slave bus
);
   localparam int unsigned CW  = $clog2(OUTS_MAX + 1);
   localparam int unsigned FCW = $clog2(IBUF_DEPTH + 1);
   localparam int unsigned SW  = FCW + 1;

   logic [CW-1:0]     outs_cnt_q, outs_cnt_d, drop_cnt_q, drop_cnt_d, pcq_cnt;
   logic              outs_lden, drop_lden;
   logic [FCW-1:0]    fifo_cnt;
   logic              fifo_full, fifo_empty, pcq_full, pcq_empty;
   logic [XLEN-1:0]   pc_head;
   logic [IBUF_W-1:0] fifo_head;
   ibuf_entry_t       head_e, rsp_e, out_e;
   logic [SW-1:0]     occ_c;
   logic              credit_c, fire_c, keep_c, byp_c, push_c, pop_c;

   // Kept fetches in flight plus buffered entries must fit in the buffer; a flush empties it.
   always_comb begin : credit
      occ_c    = SW'(outs_cnt_q - drop_cnt_q) + SW'(fifo_cnt);
      credit_c = (outs_cnt_q < CW'(OUTS_MAX)) & (flush_i | (occ_c < SW'(IBUF_DEPTH)));
   end

   assign bus.mem_cmd_valid = bus.req_i_valid & credit_c;
   assign bus.mem_cmd_addr  = bus.req_i_pc;
   assign bus.req_i_ready   = bus.mem_cmd_ready & credit_c;
   assign fire_c            = bus.req_i_valid & bus.mem_cmd_ready & credit_c;

   assign keep_c = bus.mem_rsp_valid & ~flush_i & (drop_cnt_q == '0);
`ifdef LIEAT_IFU_RSP_BYPASS_EN
   assign byp_c  = keep_c & fifo_empty & bus.ifu_o_ready;
`else
   assign byp_c  = 1'b0;
`endif
   assign push_c = keep_c & ~byp_c;
   assign pop_c  = ~fifo_empty & bus.ifu_o_ready & ~flush_i;

   assign rsp_e  = '{pc: pc_head, inst: bus.mem_rsp_data, err: bus.mem_rsp_err};
   assign head_e = ibuf_entry_t'(fifo_head);

   // Outstanding count moves with fires and responses; drop count reloads on every flush.
   always_comb begin : cnt_next
      outs_lden  = fire_c | bus.mem_rsp_valid;
      outs_cnt_d = outs_cnt_q + CW'(fire_c) - CW'(bus.mem_rsp_valid);
      drop_lden  = flush_i | (bus.mem_rsp_valid & (drop_cnt_q != '0));
      drop_cnt_d = flush_i ? (outs_cnt_q - CW'(bus.mem_rsp_valid)) : (drop_cnt_q - CW'(1));
   end

   lieat_general_dfflr #(.DW(CW)) u_outs_cnt (
      .clock(clock), .reset(reset), .lden_i(outs_lden), .d_i(outs_cnt_d), .q_o(outs_cnt_q)
   );

   lieat_general_dfflr #(.DW(CW)) u_drop_cnt (
      .clock(clock), .reset(reset), .lden_i(drop_lden), .d_i(drop_cnt_d), .q_o(drop_cnt_q)
   );

   lieat_ifu_ibuf #(.DEPTH(OUTS_MAX), .WIDTH(XLEN)) u_pcq (
      .clock   (clock),
      .reset   (reset),
      .push_i  (fire_c),
      .pop_i   (bus.mem_rsp_valid),
      .clear_i (1'b0),
      .wdata_i (bus.req_i_pc),
      .rdata_o (pc_head),
      .full_o  (pcq_full),
      .empty_o (pcq_empty),
      .count_o (pcq_cnt)
   );

   lieat_ifu_ibuf #(.DEPTH(IBUF_DEPTH), .WIDTH(IBUF_W)) u_ibuf (
      .clock   (clock),
      .reset   (reset),
      .push_i  (push_c),
      .pop_i   (pop_c),
      .clear_i (flush_i),
      .wdata_i (rsp_e),
      .rdata_o (fifo_head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_cnt)
   );

   // Output data is forced to zero while nothing is presented.
   always_comb begin : out_sel
      out_e = '0;
      if (byp_c)            out_e = rsp_e;
      else if (!fifo_empty) out_e = head_e;
      bus.ifu_o_valid = ~fifo_empty | byp_c;
      bus.ifu_o_pc    = out_e.pc;
      bus.ifu_o_inst  = out_e.inst;
      bus.ifu_o_err   = out_e.err;
   end

   always_ff @(posedge clock) begin : invariants
      if (!reset) begin
         assert (!(push_c && fifo_full && !pop_c));
         assert (!(bus.mem_rsp_valid && pcq_empty));
         assert (!(fire_c && pcq_full));
         assert (pcq_cnt == outs_cnt_q);
      end
   end

endmodule
